// File: rtl/trace_event_pkg.sv
// Purpose: shared types and constants for the trace event capture slice.
// Latency: n/a (types, constants and one pure decode function only).
// Backpressure: n/a.
// Optional build macro TRACE_EVENT_PC_EN adds a pc field to trace_event_t.
package trace_event_pkg;

    localparam logic [15:0] EVT_EXIT      = 16'h0001;
    localparam logic [15:0] EVT_REPORT    = 16'h0002;
    localparam logic [15:0] EVT_PUTC      = 16'h0004;
    localparam logic [15:0] NOP_OPCODE_HI = 16'h1500;

    // One queued event record. The field order fixes the packed layout inside the FIFO.
    typedef struct packed {
        logic [15:0] kind;
        logic [31:0] r3;
        logic [31:0] tstamp;
        logic [15:0] id;
`ifdef TRACE_EVENT_PC_EN
        logic [31:0] pc;
`endif
    } trace_event_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } cap_state_t;

    // l.nop with a non-zero immediate marks a software event.
    function automatic logic is_event_insn(input logic [31:0] insn);
        return (insn[31:16] == NOP_OPCODE_HI) && (insn[15:0] != 16'h0000);
    endfunction

endpackage

// File: rtl/trace_event_fifo.sv
// Purpose: generic synchronous first-word-fall-through FIFO.
// Latency: a push into an empty FIFO is visible on pop_dat/!empty the next cycle.
// Backpressure: push is ignored when full unless pop is also active; pop is ignored when empty.
// Ports: clk, rst (sync, active high), push/push_dat, pop/pop_dat, full, empty.
module trace_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the head slot, which is the slot being written.
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/trace_event_capture.sv
// Purpose: shadows r3, decodes l.nop K software events off the retire trace and queues timestamped records.
// Latency: an event retired in cycle N is presented on evt_* in N+1 when the queue was empty.
// Backpressure: evt_valid/evt_ready; with the queue full and no same-cycle pop, events are dropped and counted.
// Ports: clk, rst (sync, active high); trace_* retire inputs; evt_valid/evt_ready with evt_kind,
//        evt_r3, evt_time, evt_id (plus evt_pc when TRACE_EVENT_PC_EN is defined); terminated,
//        drop_cnt, r3 status outputs.
module trace_event_capture
    import trace_event_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ID         = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trace_enable,
    input  logic [31:0]          trace_pc,
    input  logic [31:0]          trace_insn,
    input  logic                 trace_wben,
    input  logic [4:0]           trace_wbreg,
    input  logic [31:0]          trace_wbdata,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [15:0]          evt_kind,
    output logic [31:0]          evt_r3,
    output logic [31:0]          evt_time,
    output logic [15:0]          evt_id,
    output logic                 terminated,
    output logic [CNT_WIDTH-1:0] drop_cnt,
    output logic [31:0]          r3
`ifdef TRACE_EVENT_PC_EN
    ,
    output logic [31:0]          evt_pc
`endif
);

    cap_state_t   state;
    cap_state_t   state_nxt;
    logic [31:0]  ts_q;
    logic         evt_hit;
    logic         push_ok;
    logic         push;
    logic         drop;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;
    trace_event_t rec;
    trace_event_t head;

    assign evt_hit = trace_enable && is_event_insn(trace_insn);
    assign pop     = evt_valid && evt_ready;
    assign push_ok = !fifo_full || pop;

    // The record takes r3 as it stood before this cycle's writeback, if any.
    always_comb begin
        rec        = '0;
        rec.kind   = trace_insn[15:0];
        rec.r3     = r3;
        rec.tstamp = ts_q;
        rec.id     = 16'(ID);
`ifdef TRACE_EVENT_PC_EN
        rec.pc     = trace_pc;
`endif
    end

`ifndef TRACE_EVENT_PC_EN
    // The PC is not stored in this build.
    logic unused_pc;
    assign unused_pc = &{1'b0, trace_pc};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        push       = 1'b0;
        drop       = 1'b0;
        terminated = 1'b0;
        case (state)
            ST_RUN: begin
                if (evt_hit) begin
                    push = push_ok;
                    drop = !push_ok;
                    // EXIT terminates whether or not its record found a slot.
                    if (trace_insn[15:0] == EVT_EXIT) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                terminated = 1'b1;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q     <= '0;
            r3       <= '0;
            drop_cnt <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (trace_enable && trace_wben && (trace_wbreg == 5'd3)) begin
                r3 <= trace_wbdata;
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

    trace_event_fifo #(
        .WIDTH ($bits(trace_event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (rec),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign evt_kind  = head.kind;
    assign evt_r3    = head.r3;
    assign evt_time  = head.tstamp;
    assign evt_id    = head.id;
`ifdef TRACE_EVENT_PC_EN
    assign evt_pc    = head.pc;
`endif

endmodule

// File: tb/tb_trace_event_capture.sv
// Purpose: self-checking bench for trace_event_capture (decode table, scoreboard, corner sequences).
// Latency: the reference model commits state on each rising edge; outputs are sampled off-edge.
// Backpressure: evt_ready is driven per phase; the scoreboard pops only on accepted transfers.
module tb_trace_event_capture;
    import trace_event_pkg::*;

    localparam int DEPTH = 8;
    localparam int TID   = 5;

    logic        clk;
    logic        rst;
    logic        trace_enable;
    logic [31:0] trace_pc;
    logic [31:0] trace_insn;
    logic        trace_wben;
    logic [4:0]  trace_wbreg;
    logic [31:0] trace_wbdata;
    logic        evt_valid;
    logic        evt_ready;
    logic [15:0] evt_kind;
    logic [31:0] evt_r3;
    logic [31:0] evt_time;
    logic [15:0] evt_id;
    logic        terminated;
    logic [15:0] drop_cnt;
    logic [31:0] r3;
`ifdef TRACE_EVENT_PC_EN
    logic [31:0] evt_pc;
`endif

    trace_event_capture #(
        .FIFO_DEPTH (DEPTH),
        .ID         (TID),
        .CNT_WIDTH  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trace_enable (trace_enable),
        .trace_pc     (trace_pc),
        .trace_insn   (trace_insn),
        .trace_wben   (trace_wben),
        .trace_wbreg  (trace_wbreg),
        .trace_wbdata (trace_wbdata),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_kind     (evt_kind),
        .evt_r3       (evt_r3),
        .evt_time     (evt_time),
        .evt_id       (evt_id),
        .terminated   (terminated),
        .drop_cnt     (drop_cnt),
        .r3           (r3)
`ifdef TRACE_EVENT_PC_EN
        ,
        .evt_pc       (evt_pc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] kind;
        logic [31:0] r3;
        logic [31:0] ts;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic        en;
        logic [31:0] insn;
        logic        wben;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
        logic        exp_vld;
        logic [15:0] exp_kind;
        logic [31:0] exp_r3;
    } vec_t;

    exp_t        q[$];
    int          checks = 0;
    int          passes = 0;
    int          pops   = 0;
    logic [31:0] r3_m;
    int          drop_m;
    bit          done_m;
    logic [31:0] cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Drives one retire-trace cycle, predicts its effect and commits the prediction at the edge.
    task automatic cycle(input logic en, input logic [31:0] insn, input logic [31:0] pc,
                         input logic wben, input logic [4:0] wbreg, input logic [31:0] wbdata);
        bit   p_r3, p_push, p_drop, p_done;
        exp_t p_rec;
        trace_enable = en;
        trace_insn   = insn;
        trace_pc     = pc;
        trace_wben   = wben;
        trace_wbreg  = wbreg;
        trace_wbdata = wbdata;
        p_r3   = en && wben && (wbreg == 5'd3);
        p_push = 1'b0;
        p_drop = 1'b0;
        p_done = 1'b0;
        p_rec  = '{kind: insn[15:0], r3: r3_m, ts: cyc, pc: pc};
        if (en && insn[31:16] == 16'h1500 && insn[15:0] != 16'h0 && !done_m) begin
            if (q.size() < DEPTH || evt_ready) p_push = 1'b1;
            else p_drop = 1'b1;
            if (insn[15:0] == 16'h0001) p_done = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc = cyc + 32'd1;
        if (p_r3) r3_m = wbdata;
        if (p_push) q.push_back(p_rec);
        if (p_drop && drop_m < 65535) drop_m++;
        if (p_done) done_m = 1'b1;
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        trace_enable = 1'b1;
        trace_insn   = 32'h15000004;
        trace_wben   = 1'b1;
        trace_wbreg  = 5'd3;
        trace_wbdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        r3_m   = 32'h0;
        drop_m = 0;
        done_m = 1'b0;
        q.delete();
        cyc    = 32'h0;
    endtask

    task automatic drain(input string name);
        evt_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() != 0; i++) idle();
        chk({name, "_drained"}, evt_valid, 1'b0);
    endtask

    // Scoreboard: head fields must match the oldest expected record every valid cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("evt_valid", evt_valid, q.size() != 0);
            if (evt_valid && q.size() != 0) begin
                chk("evt_kind", evt_kind, q[0].kind);
                chk("evt_r3", evt_r3, q[0].r3);
                chk("evt_time", evt_time, q[0].ts);
                chk("evt_id", evt_id, 16'(TID));
`ifdef TRACE_EVENT_PC_EN
                chk("evt_pc", evt_pc, q[0].pc);
`endif
                if (evt_ready) begin
                    q.delete(0);
                    pops++;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[8];
    int   pops0;

    initial begin
        tbl[0] = '{1'b1, 32'h0000_0000, 1'b1, 5'd3, 32'h0000_1234, 1'b0, 16'h0,    32'h0000_1234};
        tbl[1] = '{1'b1, 32'h1500_0000, 1'b0, 5'd0, 32'h0,         1'b0, 16'h0,    32'h0000_1234};
        tbl[2] = '{1'b1, 32'h1500_0002, 1'b0, 5'd0, 32'h0,         1'b1, 16'h0002, 32'h0000_1234};
        tbl[3] = '{1'b0, 32'h1500_0004, 1'b1, 5'd3, 32'h0000_dead, 1'b0, 16'h0,    32'h0000_1234};
        tbl[4] = '{1'b1, 32'h1501_0004, 1'b1, 5'd4, 32'h0000_beef, 1'b0, 16'h0,    32'h0000_1234};
        tbl[5] = '{1'b1, 32'h1500_abcd, 1'b0, 5'd3, 32'h0,         1'b1, 16'habcd, 32'h0000_1234};
        tbl[6] = '{1'b1, 32'h8c00_0000, 1'b1, 5'd3, 32'hcafe_f00d, 1'b0, 16'h0,    32'hcafe_f00d};
        tbl[7] = '{1'b1, 32'h1500_ffff, 1'b1, 5'd3, 32'h0000_0055, 1'b1, 16'hffff, 32'h0000_0055};

        evt_ready = 1'b0;
        do_reset();
        do_reset();
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_terminated", terminated, 1'b0);
        chk("rst_drop_cnt", drop_cnt, 16'h0);
        chk("rst_r3", r3, 32'h0);

        // Decode and shadow table, consumer always ready.
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].en, tbl[i].insn, 32'h1000 + 32'(i * 4), tbl[i].wben, tbl[i].wbreg, tbl[i].wbdata);
            chk($sformatf("tbl%0d_r3", i), r3, tbl[i].exp_r3);
            chk($sformatf("tbl%0d_valid", i), evt_valid, tbl[i].exp_vld);
            if (tbl[i].exp_vld) chk($sformatf("tbl%0d_kind", i), evt_kind, tbl[i].exp_kind);
        end
        drain("tbl");

        // r3 write in cycle 5, putc in cycle 7, record visible in cycle 8.
        evt_ready = 1'b0;
        do_reset();
        while (cyc < 32'd5) idle();
        cycle(1'b1, 32'h9c60_0041, 32'h200, 1'b1, 5'd3, 32'h41);
        idle();
        chk("putc_not_early", evt_valid, 1'b0);
        cycle(1'b1, 32'h1500_0004, 32'h208, 1'b0, 5'd0, 32'h0);
        chk("putc_valid", evt_valid, 1'b1);
        chk("putc_kind", evt_kind, 16'h0004);
        chk("putc_r3", evt_r3, 32'h41);
        chk("putc_time", evt_time, 32'd7);
        drain("putc");

        // Event and r3 writeback in the same cycle.
        cycle(1'b1, 32'h9c60_0010, 32'h300, 1'b1, 5'd3, 32'h10);
        cycle(1'b1, 32'h1500_0002, 32'h304, 1'b1, 5'd3, 32'h20);
        chk("same_r3_shadow", r3, 32'h20);
        chk("same_evt_r3", evt_r3, 32'h10);
        drain("same");

        // Overflow: 11 events into 8 slots, then a push while full with a pop.
        evt_ready = 1'b0;
        for (int i = 0; i < 11; i++) cycle(1'b1, 32'h1500_0004, 32'h400 + 32'(i), 1'b0, 5'd0, 32'h0);
        chk("ovf_drop_cnt", drop_cnt, 16'd3);
        chk("ovf_valid", evt_valid, 1'b1);
        pops0 = pops;
        evt_ready = 1'b1;
        cycle(1'b1, 32'h1500_0002, 32'h4ff, 1'b0, 5'd0, 32'h0);
        chk("ovf_full_push_drop_cnt", drop_cnt, 16'd3);
        drain("ovf");
        chk("ovf_delivered", 64'(pops - pops0), 64'd9);

        // Backpressure: two records, ready toggled.
        evt_ready = 1'b0;
        cycle(1'b1, 32'h9c60_0077, 32'h500, 1'b1, 5'd3, 32'h77);
        cycle(1'b1, 32'h1500_0002, 32'h504, 1'b1, 5'd3, 32'h88);
        cycle(1'b1, 32'h1500_0004, 32'h508, 1'b0, 5'd0, 32'h0);
        pops0 = pops;
        foreach (tbl[i]) begin
            evt_ready = i[0] ^ i[1];
            idle();
        end
        drain("bp");
        chk("bp_delivered", 64'(pops - pops0), 64'd2);

        // Termination by EXIT, later events ignored, shadow keeps running.
        evt_ready = 1'b1;
        cycle(1'b1, 32'h9c60_0000, 32'h600, 1'b1, 5'd3, 32'h0);
        cycle(1'b1, 32'h1500_0001, 32'h604, 1'b0, 5'd0, 32'h0);
        chk("exit_terminated", terminated, 1'b1);
        evt_ready = 1'b0;
        idle();
        cycle(1'b1, 32'h1500_0004, 32'h608, 1'b0, 5'd0, 32'h0);
        idle();
        chk("done_drop_cnt", drop_cnt, 16'd3);
        cycle(1'b1, 32'h9c60_0099, 32'h60c, 1'b1, 5'd3, 32'h99);
        chk("done_r3_runs", r3, 32'h99);
        drain("done");
        chk("done_sticky", terminated, 1'b1);

        // A dropped EXIT still terminates, then a mid-stream reset clears everything.
        evt_ready = 1'b0;
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h1500_0004, 32'h700 + 32'(i), 1'b0, 5'd0, 32'h0);
        cycle(1'b1, 32'h1500_0001, 32'h7f0, 1'b0, 5'd0, 32'h0);
        chk("drop_exit_cnt", drop_cnt, 16'd1);
        chk("drop_exit_terminated", terminated, 1'b1);
        do_reset();
        chk("mid_rst_valid", evt_valid, 1'b0);
        chk("mid_rst_terminated", terminated, 1'b0);
        chk("mid_rst_drop_cnt", drop_cnt, 16'h0);
        chk("mid_rst_r3", r3, 32'h0);
        cycle(1'b1, 32'h1500_0002, 32'h800, 1'b0, 5'd0, 32'h0);
        chk("mid_rst_time0", evt_time, 32'd0);
        drain("mid_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/trace_event_capture.md
Name: trace_event_capture

Overview:
- Per-core stage directly downstream of the compute-tile execution trace port (`DEBUG_TRACE_EXEC_*` fields).
- Keeps a shadow copy of GPR r3 and decodes software event instructions (l.nop K, K≠0).
- Queues timestamped event records into a FIFO with a valid/ready output.
- Consumers are the simulation stdout/termination monitors and host debug logic.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, ≥2.
- ID, 0, core index, copied into every record.
- CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- trace_enable  in  1  trace entry valid (instruction retired)
- trace_pc  in  32  retired PC
- trace_insn  in  32  retired instruction
- trace_wben  in  1  GPR writeback enable
- trace_wbreg  in  5  writeback register index
- trace_wbdata  in  32  writeback data
- evt_valid  out  1  head record valid
- evt_ready  in  1  consumer accepts head record
- evt_kind  out  16  K field of the l.nop
- evt_r3  out  32  r3 value at retirement
- evt_time  out  32  cycle timestamp
- evt_id  out  16  ID
- terminated  out  1  sticky; EXIT event seen
- drop_cnt  out  CNT_WIDTH  saturating count of lost events
- r3  out  32  current r3 shadow

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values: evt_valid=0, terminated=0, drop_cnt=0, r3=0, timestamp counter=0, FIFO empty.
- Timestamp: 32-bit free-running counter, +1 every cycle, wraps 0xFFFFFFFF→0. A record carries the counter value of its retirement cycle.
- r3 shadow update: on trace_enable && trace_wben && trace_wbreg==3, r3 ← trace_wbdata, visible the next cycle.
- Event detection: trace_enable && trace_insn[31:16]==16'h1500 && trace_insn[15:0]!=0.
  - Recorded r3 is the shadow value before that cycle; an l.nop never writes back.
  - If wben/wbreg==3 asserts in the same cycle, the shadow still updates, but the record uses the pre-update value.
- Kinds (package constants): EXIT=0x0001, REPORT=0x0002, PUTC=0x0004, others are passed through unchanged.
- Capture FSM states:
  - RUN: events are pushed.
  - DONE: entered on the cycle after an accepted or dropped EXIT event; terminated=1. Further events are ignored and neither pushed nor counted. The r3 shadow and timestamp keep running.
  - rst is the only exit from DONE.
- Push rules:
  - Push if not full, or if full && evt_ready && evt_valid (simultaneous pop frees a slot).
  - Otherwise drop the event; drop_cnt increments, saturating at all-ones.
  - A dropped EXIT still sets terminated.
- Output handshake:
  - First-word-fall-through: a record pushed in cycle N on an empty FIFO gives evt_valid=1 in N+1.
  - A transfer occurs when evt_valid && evt_ready. Output fields are stable while evt_valid && !evt_ready.
  - evt_ready while empty has no effect.
- Pointers: log2(FIFO_DEPTH)+1 bits; full/empty from MSB compare; wrap is modulo.
- Reset mid-operation discards all queued records in one cycle. trace inputs are ignored in the reset cycle.

Optional Feature:
- Macro TRACE_EVENT_PC_EN.
- Defined: adds output evt_pc (32), the trace_pc of the event instruction, stored per FIFO entry.
- Undefined: no evt_pc port, and FIFO entries omit the PC bits.

Decomposition:
- Package trace_event_pkg:
  - kind constants EVT_EXIT, EVT_REPORT, EVT_PUTC, and NOP_OPCODE_HI=16'h1500;
  - packed struct trace_event_t {kind, r3, time, id[, pc]}.
- Sub-module trace_event_fifo: generic synchronous FWFT FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty.
- Top module: r3 shadow, decode, timestamp, FSM, drop counter.

Test Plan:
- r3 write then putc: wb r3=0x41 in cycle 5, l.nop 0x0004 (insn 0x15000004) in cycle 7 → record kind=0x0004, r3=0x41, time=7, evt_valid in cycle 8.
- Same-cycle r3 write with event: shadow r3=0x10, event cycle asserts wb r3=0x20 → record r3=0x10; r3 output=0x20 next cycle.
- Overflow: FIFO_DEPTH=8, evt_ready=0, 11 putc events → 8 queued, drop_cnt=3. Then evt_ready=1 with a simultaneous event while full → event accepted, drop_cnt stays 3.
- Termination: l.nop 0x0001 with r3=0 → terminated=1 next cycle; subsequent l.nop 0x0004 → no push, drop_cnt unchanged.
- Backpressure stability: two queued records, evt_ready toggled 0/1 → fields constant while stalled, records delivered in order with no duplicates.
- Reset mid-stream: 3 queued records plus terminated=1, assert rst for 1 cycle → evt_valid=0, terminated=0, drop_cnt=0, timestamp restarts at 0.
